// File: rtl/multi_axis_motion_predictor.sv
// Per-axis linear extrapolator over a 2^HIST_LOG2+1 sample history ring; pred_valid pulses 2 cycles after the triggering accept.
// s_ready drops while a prediction is in flight (CALC/EMIT), on flush and during reset; duplicates are consumed without effect.
module multi_axis_motion_predictor #(
    parameter int COORD_W      = 8,
    parameter int NAXES        = 2,
    parameter int HIST_LOG2    = 4,
    parameter int LOOKAHEAD    = 10,
    parameter int UPDATE_EVERY = 10
) (
    input  logic                     clk50mhz,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [NAXES*COORD_W-1:0] s_pos,
    input  logic [1:0]               mode,
    input  logic                     flush,
    output logic                     pred_valid,
    output logic [NAXES*COORD_W-1:0] pred_pos,
    output logic [NAXES-1:0]         pred_sat,
    output logic                     hist_full
);
    localparam int DEPTH = (1 << HIST_LOG2) + 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int P_W   = COORD_W + 10;

    localparam logic [CNT_W-1:0]       DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]       ALMOST  = CNT_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0]       PTR_END = PTR_W'(DEPTH - 1);
    localparam logic [7:0]             UPD_C   = 8'(UPDATE_EVERY);
    localparam logic [COORD_W-1:0]     MID     = COORD_W'(1 << (COORD_W - 1));
    localparam logic signed [P_W-1:0]  MAXV    = P_W'((1 << COORD_W) - 1);
    localparam logic signed [P_W-1:0]  LOOK_C  = P_W'(LOOKAHEAD);

    typedef enum logic [1:0] {COLLECT, CALC, EMIT} state_t;

    state_t                   state;
    logic [NAXES*COORD_W-1:0] ring [DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [CNT_W-1:0]         count;
    logic [7:0]               trig_cnt;
    logic [NAXES*COORD_W-1:0] last_dat;
    logic                     last_vld;
    logic                     passthru;
    logic [NAXES*COORD_W-1:0] res_dat;
    logic [NAXES-1:0]         res_sat;
    logic [NAXES*COORD_W-1:0] calc_pos;
    logic [NAXES-1:0]         calc_sat;

    logic       accept_vld, dup, store_vld, fire;
    logic [7:0] trig_nxt;

    assign s_ready    = (state == COLLECT) && !flush && !rst;
    assign accept_vld = s_valid && s_ready;
    assign dup        = last_vld && (s_pos == last_dat);
    assign store_vld  = accept_vld && !dup;

    // Counter is primed on the filling sample so the first full history fires immediately in mode 0.
    assign trig_nxt = (count == ALMOST)  ? UPD_C :
                      (count == DEPTH_C) ? trig_cnt + 8'd1 : trig_cnt;
    assign fire     = store_vld && ((mode == 2'd1) || ((mode == 2'd0) && (trig_nxt == UPD_C)));

    // With a full ring the slot about to be overwritten is the oldest sample.
    for (genvar k = 0; k < NAXES; k++) begin : g_axis
        logic [COORD_W-1:0]      newest, oldest;
        logic signed [COORD_W:0] delta, vel;
        logic signed [P_W-1:0]   p;
        logic                    neg, over;

        assign newest = last_dat[k*COORD_W +: COORD_W];
        assign oldest = ring[wr_ptr][k*COORD_W +: COORD_W];
        assign delta  = $signed({1'b0, newest}) - $signed({1'b0, oldest});
        assign vel    = delta >>> HIST_LOG2;
        assign p      = $signed({{(P_W-COORD_W){1'b0}}, newest}) + P_W'(vel) * LOOK_C;
        assign neg    = p[P_W-1];
        assign over   = !neg && (p > MAXV);
        assign calc_sat[k] = neg || over;
        assign calc_pos[k*COORD_W +: COORD_W] = neg  ? '0 :
                                                over ? '1 : p[COORD_W-1:0];
    end

    always_ff @(posedge clk50mhz) begin
        if (store_vld) ring[wr_ptr] <= s_pos;
    end

    always_ff @(posedge clk50mhz) begin
        if (rst) begin
            state      <= COLLECT;
            wr_ptr     <= '0;
            count      <= '0;
            trig_cnt   <= '0;
            last_dat   <= '0;
            last_vld   <= 1'b0;
            passthru   <= 1'b0;
            res_dat    <= '0;
            res_sat    <= '0;
            pred_valid <= 1'b0;
            pred_pos   <= {NAXES{MID}};
            pred_sat   <= '0;
            hist_full  <= 1'b0;
        end else begin
            pred_valid <= 1'b0;
            if (flush) begin
                state     <= COLLECT;
                count     <= '0;
                trig_cnt  <= '0;
                hist_full <= 1'b0;
                last_vld  <= 1'b0;
            end else begin
                case (state)
                    COLLECT: begin
                        if (store_vld) begin
                            wr_ptr    <= (wr_ptr == PTR_END) ? '0 : wr_ptr + PTR_W'(1);
                            last_dat  <= s_pos;
                            last_vld  <= 1'b1;
                            if (count != DEPTH_C) count <= count + CNT_W'(1);
                            hist_full <= (count >= ALMOST);
                            trig_cnt  <= fire ? 8'd0 : trig_nxt;
                            if (fire) begin
                                passthru <= (mode == 2'd1);
                                state    <= CALC;
                            end
                        end
                    end
                    CALC: begin
                        res_dat <= passthru ? last_dat : calc_pos;
                        res_sat <= passthru ? '0 : calc_sat;
                        state   <= EMIT;
                    end
                    EMIT: begin
                        pred_pos   <= res_dat;
                        pred_sat   <= res_sat;
                        pred_valid <= 1'b1;
                        state      <= COLLECT;
                    end
                    default: state <= COLLECT;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_multi_axis_motion_predictor.sv
// Bench for multi_axis_motion_predictor: directed scenarios plus random traffic against a history-queue model.
module tb_multi_axis_motion_predictor;
    localparam int UE = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_pos = '0;
    logic [1:0]  mode = 2'd0;
    logic        flush = 1'b0;
    logic        pred_valid;
    logic [15:0] pred_pos;
    logic [1:0]  pred_sat;
    logic        hist_full;

    multi_axis_motion_predictor #(
        .COORD_W(8), .NAXES(2), .HIST_LOG2(4), .LOOKAHEAD(10), .UPDATE_EVERY(UE)
    ) dut (
        .clk50mhz(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_pos(s_pos),
        .mode(mode), .flush(flush), .pred_valid(pred_valid), .pred_pos(pred_pos),
        .pred_sat(pred_sat), .hist_full(hist_full)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the history is just the last 17 distinct samples in arrival order.
    logic [15:0] hist[$];
    logic [15:0] m_last;
    bit          m_last_vld;
    int          m_trig;
    int          m_pend;
    logic [15:0] m_res;
    logic [1:0]  m_res_sat;
    logic [15:0] e_pos = 16'h8080;
    logic [1:0]  e_sat = 2'b00;
    logic        e_valid = 1'b0;
    bit          m_accepted;

    function automatic logic [15:0] pk(input int x, input int y);
        logic [15:0] v;
        v = {y[7:0], x[7:0]};
        return v;
    endfunction

    function automatic int fdiv(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic predict(input bit passthrough);
        logic [15:0] nw, od;
        int n, o, p;
        nw = hist[hist.size()-1];
        od = hist[0];
        for (int k = 0; k < 2; k++) begin
            n = int'(nw[k*8 +: 8]);
            o = int'(od[k*8 +: 8]);
            if (passthrough) begin
                p = n;
                m_res_sat[k] = 1'b0;
            end else begin
                p = n + fdiv(n - o, 16) * 10;
                m_res_sat[k] = (p < 0) || (p > 255);
                if (p < 0) p = 0;
                if (p > 255) p = 255;
            end
            m_res[k*8 +: 8] = p[7:0];
        end
    endtask

    task automatic model_step();
        int prev;
        bit do_fire;
        m_accepted = 1'b0;
        e_valid = 1'b0;
        if (rst) begin
            hist.delete();
            m_last_vld = 1'b0;
            m_trig = 0;
            m_pend = 0;
            e_pos = 16'h8080;
            e_sat = 2'b00;
        end else if (flush) begin
            hist.delete();
            m_last_vld = 1'b0;
            m_trig = 0;
            m_pend = 0;
        end else if (m_pend > 0) begin
            m_pend--;
            if (m_pend == 0) begin
                e_pos = m_res;
                e_sat = m_res_sat;
                e_valid = 1'b1;
            end
        end else if (s_valid) begin
            m_accepted = 1'b1;
            if (!(m_last_vld && s_pos == m_last)) begin
                prev = hist.size();
                hist.push_back(s_pos);
                if (hist.size() > 17) void'(hist.pop_front());
                m_last = s_pos;
                m_last_vld = 1'b1;
                if (prev == 16) m_trig = UE;
                else if (prev == 17) m_trig = (m_trig + 1) % 256;
                do_fire = (mode == 2'd1) || (mode == 2'd0 && m_trig == UE);
                if (do_fire) begin
                    m_trig = 0;
                    m_pend = 2;
                    predict(mode == 2'd1);
                end
            end
        end
    endtask

    // One clock: check the combinational ready, advance the model, then check registered outputs.
    task automatic tick();
        #1;
        chk("s_ready", 32'(s_ready), 32'(!rst && !flush && m_pend == 0));
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("pred_valid", 32'(pred_valid), 32'(e_valid));
        chk("pred_pos", 32'(pred_pos), 32'(e_pos));
        chk("pred_sat", 32'(pred_sat), 32'(e_sat));
        chk("hist_full", 32'(hist_full), 32'(hist.size() == 17));
    endtask

    task automatic send(input logic [15:0] v, input logic [1:0] md);
        int budget;
        s_valid = 1'b1;
        s_pos = v;
        mode = md;
        budget = 20;
        do begin
            tick();
            budget--;
        end while (!m_accepted && budget > 0);
        if (!m_accepted) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout actual=not_accepted required=accepted value=%0h", v);
        end
        s_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("reset_pos", 32'(pred_pos), 32'h8080);
        chk("reset_full", 32'(hist_full), 32'h0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", 32'(s_ready), 32'h1);

        // Ramp on x, constant y: first prediction, then one UPDATE_EVERY later.
        for (int i = 0; i <= 16; i++) send(pk(100 + i, 50), 2'd0);
        tick(); tick();
        chk("t1_valid", 32'(pred_valid), 32'h1);
        chk("t1_pos", 32'(pred_pos), 32'h327E);
        chk("t1_sat", 32'(pred_sat), 32'h0);
        for (int i = 17; i <= 26; i++) send(pk(100 + i, 50), 2'd0);
        tick(); tick();
        chk("t1b_pos", 32'(pred_pos), 32'h3288);

        // Opposite slopes: x clamps to 0, y extrapolates to 252.
        do_reset();
        for (int i = 0; i <= 16; i++) send(pk(40 - 2 * i, 200 + 2 * i), 2'd0);
        tick(); tick();
        chk("t2_valid", 32'(pred_valid), 32'h1);
        chk("t2_pos", 32'(pred_pos), 32'hFC00);
        chk("t2_sat", 32'(pred_sat), 32'h1);

        // Duplicates are discarded; a midscale first sample is still stored.
        do_reset();
        send(pk(1, 1), 2'd0); send(pk(2, 1), 2'd0); send(pk(3, 1), 2'd0);
        for (int i = 0; i < 5; i++) send(pk(3, 1), 2'd0);
        tick(); tick(); tick();
        chk("t3_full", 32'(hist_full), 32'h0);
        do_reset();
        send(16'h8080, 2'd1);
        tick(); tick();
        chk("t3_mid_valid", 32'(pred_valid), 32'h1);
        chk("t3_mid_pos", 32'(pred_pos), 32'h8080);

        // Passthrough with interleaved duplicates.
        for (int i = 0; i < 6; i++) begin
            send(pk(10 * i + 5, 255 - i), 2'd1);
            send(pk(10 * i + 5, 255 - i), 2'd1);
            tick(); tick();
        end
        chk("t4_pos", 32'(pred_pos), 32'hFA37);

        // Floor of -1/16 is -1: x = 59 - 10 = 49.
        do_reset();
        for (int i = 0; i <= 16; i++) send(pk(i == 0 ? 60 : 59, i % 2), 2'd0);
        tick(); tick();
        chk("t5_valid", 32'(pred_valid), 32'h1);
        chk("t5_pos", 32'(pred_pos), 32'h0031);
        do_reset();
        for (int i = 0; i <= 16; i++) send(pk(i == 0 ? 60 : 59, i % 2), 2'd2);
        tick(); tick(); tick();
        chk("t5_hold_full", 32'(hist_full), 32'h1);
        chk("t5_hold_pos", 32'(pred_pos), 32'h8080);

        // Flush during CALC aborts; reset mid-collection restores midscale.
        do_reset();
        for (int i = 0; i <= 16; i++) send(pk(100 + i, 50), 2'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick(); tick();
        chk("t6_flush_valid", 32'(pred_valid), 32'h0);
        chk("t6_flush_full", 32'(hist_full), 32'h0);
        chk("t6_flush_pos", 32'(pred_pos), 32'h8080);
        for (int i = 0; i <= 16; i++) send(pk(7 * i, 3 * i), 2'd0);
        tick(); tick();
        for (int i = 0; i < 3; i++) send(pk(i, 9), 2'd0);
        do_reset();
        chk("t6_rst_pos", 32'(pred_pos), 32'h8080);
        chk("t6_rst_full", 32'(hist_full), 32'h0);
        for (int i = 0; i <= 16; i++) send(pk(20 + i, 30), 2'd0);
        tick(); tick();
        chk("t6_restart_valid", 32'(pred_valid), 32'h1);

        // Random traffic; duplicates and ramps are biased in to keep the history interesting.
        for (int i = 0; i < 4000; i++) begin
            int r;
            rst   = ($urandom_range(0, 299) == 0);
            flush = ($urandom_range(0, 149) == 0);
            r = $urandom_range(0, 19);
            mode    = (r < 14) ? 2'd0 : (r < 17) ? 2'd1 : 2'($urandom_range(2, 3));
            s_valid = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 3);
            if (r == 1) s_pos = s_pos + 16'h0101;
            else if (r == 2) s_pos = 16'($urandom);
            else if (r == 3) s_pos = {s_pos[15:8] - 8'd3, s_pos[7:0] + 8'd5};
            tick();
        end
        rst = 1'b0;
        flush = 1'b0;
        s_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/multi_axis_motion_predictor.md
Name: multi_axis_motion_predictor

Overview:
Parametrised linear motion predictor for the guidance path. Accepts decoded target position samples for NAXES axes over a valid/ready handshake and keeps a per-axis history ring of 2^HIST_LOG2+1 distinct samples. It extrapolates each axis LOOKAHEAD sample-intervals ahead with saturation. The predicted position feeds the servo PWM stage; the UART byte decoder sits upstream.

Parameters:
COORD_W, 8, bits per axis coordinate (unsigned)
NAXES, 2, number of axes
HIST_LOG2, 4, history spans 2^HIST_LOG2 intervals; DEPTH = 2^HIST_LOG2+1 stored samples
LOOKAHEAD, 10, extrapolation distance in sample intervals (1..255)
UPDATE_EVERY, 10, distinct samples between successive predictions once history is full (1..255)

Ports:
clk50mhz  in  1  sole clock
rst  in  1  synchronous, active-high reset
s_valid  in  1  sample valid
s_ready  out  1  sample accepted when s_valid && s_ready
s_pos  in  NAXES*COORD_W  sample; axis k at [k*COORD_W +: COORD_W]
mode  in  2  0=predict, 1=passthrough, 2/3=hold
flush  in  1  single-cycle history clear
pred_valid  out  1  one-cycle pulse: pred_pos updated
pred_pos  out  NAXES*COORD_W  last predicted position (held)
pred_sat  out  NAXES  per-axis clamp flag for the current pred_pos
hist_full  out  1  DEPTH distinct samples stored

Behaviour:
- Reset: pred_pos = 2^(COORD_W-1) per axis; pred_valid=0, pred_sat=0, hist_full=0, count=0, last-sample-valid=0. s_ready=0 while rst is high and 1 on the first cycle after.
- FSM states: COLLECT, CALC, EMIT. s_ready=1 only in COLLECT with flush low.
- COLLECT, on accept: the sample is a duplicate if last-sample-valid is set and all axes equal the last stored sample. A duplicate is consumed and discarded, with no state change.
- COLLECT, on accept of a non-duplicate: store the sample as the newest entry (ring write, oldest overwritten when full) and set last = sample.
  - Count saturates at DEPTH; hist_full = (count==DEPTH).
  - The trigger counter increments on each stored sample while already full. On the sample that makes count reach DEPTH it is loaded to UPDATE_EVERY.
- Trigger fires on a stored sample when mode=1 (any count), or when mode=0 and the trigger counter equals UPDATE_EVERY. On fire: trigger counter clears and the FSM goes to CALC. mode is sampled at this acceptance.
- mode 2/3: samples are stored and the trigger counter runs, but the FSM never leaves COLLECT.
- CALC (1 cycle), per axis:
  - delta = newest − oldest, signed COORD_W+1.
  - vel = delta >>> HIST_LOG2 (arithmetic; floors toward −inf, e.g. −1 → −1).
  - p = newest + vel*LOOKAHEAD in signed COORD_W+10 bits (no intermediate overflow).
  - Result = clamp(p, 0, 2^COORD_W−1); sat = (p<0)||(p>2^COORD_W−1).
  - Passthrough: result = newest, sat=0.
- EMIT (1 cycle): pred_pos and pred_sat registered, pred_valid=1, return to COLLECT.
- Latency: pred_valid is high exactly 2 cycles after the triggering accept edge. Back-to-back acceptance resumes the cycle after pred_valid.
- History is not cleared after a prediction. The next mode-0 prediction comes after UPDATE_EVERY further distinct samples.
- flush: highest priority after rst. It clears count, the trigger counter, hist_full and last-sample-valid, and forces COLLECT.
  - A flush in CALC/EMIT aborts the result: no pred_valid, pred_pos/pred_sat unchanged.
  - s_ready=0 in the flush cycle, so no sample is accepted.
- rst mid-CALC/EMIT: same as the reset values above; no pulse.

Test Plan:
1. mode=0, NAXES=2: x=100,101..116, y=50 constant (17 distinct samples) → 2 cycles after the 17th accept, pred_valid=1, pred_pos x=126 y=50, pred_sat=00. Then 10 more x steps (117..126) → second pulse with x=136.
2. x from 40 down to 8 step −2, y=200 up to 232 step +2 → vel −2/+2; x clamps to 0, y=252; pred_sat=01 (x axis).
3. Send the same sample 5 times after 3 distinct samples → count stays 3, hist_full=0, no pred_valid. The first sample after reset equal to midscale is stored (count=1).
4. mode=1: each distinct sample gives pred_pos=sample 2 cycles later. Duplicates give no pulse; s_ready=0 during CALC/EMIT.
5. Floor check: 17 samples where newest−oldest=−1 (e.g. 60 then 59 repeated via alternating y) → vel=−1, x pred=49. mode=2 on the same stimulus → no pred_valid, hist_full=1.
6. flush asserted in CALC → no pred_valid, hist_full=0, pred_pos unchanged. rst mid-collection → pred_pos=128,128 and count restarts at 0.
